// File: rtl/tt_um_secd_8_seq_div_if.sv
// Tiny Tapeout pin bundle for the sequential divider tile.
//   ena     : tile enable (ignored by the divider)
//   ui_in   : dividend
//   uio_in  : [3:0] divisor, [4] start, [5] result view select
//   uo_out  : quotient, or {dz,3'b0,remainder} when select is high
//   uio_out : [6] busy, [7] done
//   uio_oe  : bidirectional output enables
// master = pad/host side, slave = divider side.
interface tt_um_secd_8_seq_div_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/tt_um_secd_8_seq_div.sv
// Sequential restoring divider tile: DW-bit unsigned dividend / VW-bit unsigned
// divisor, one quotient bit per clock, MSB first.
// Top ports (Tiny Tapeout pinout):
//   clk, rst_n (async active-low), ena (ignored)
//   ui_in   : dividend
//   uio_in  : [3:0] divisor, [4] start (synchronised, rising-edge), [5] sel
//   uo_out  : sel=0 quotient, sel=1 {dz,3'b0,remainder}
//   uio_out : [6] busy, [7] done;  uio_oe : 8'hC0
// The core talks to the pins through tt_um_secd_8_seq_div_if.

module tt_um_secd_8_seq_div_core #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  tt_um_secd_8_seq_div_if.slave   bus
);
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          r_state, w_state_n;
  logic            r_start_m, r_start_s, r_start_q;
  logic [DW-1:0]   r_dvd, w_dvd_n;
  logic [VW-1:0]   r_dvs, w_dvs_n;
  logic [DW-1:0]   r_q, w_q_n;
  logic [VW-1:0]   r_rem, w_rem_n;
  logic            r_dz, w_dz_n;
  logic            r_busy, w_busy_n;
  logic            r_done, w_done_n;
  logic [CW-1:0]   r_cnt, w_cnt_n;

  logic            w_start_edge;
  logic [VW:0]     w_rem5;
  logic [VW:0]     w_diff;
  logic            w_unused;

  assign w_start_edge = r_start_s & ~r_start_q;
  // Partial remainder never exceeds 2*divisor-1, so VW+1 bits cannot overflow
  // and the top bit of the difference is always 0 when it is used.
  assign w_rem5       = {r_rem, r_dvd[DW-1]};
  assign w_diff       = w_rem5 - {1'b0, r_dvs};
  assign w_unused     = &{1'b0, bus.ena, bus.uio_in[7:6], w_diff[VW]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_start_m <= 1'b0;
      r_start_s <= 1'b0;
      r_start_q <= 1'b0;
      r_dvd     <= '0;
      r_dvs     <= '0;
      r_q       <= '0;
      r_rem     <= '0;
      r_dz      <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_n;
      r_start_m <= bus.uio_in[4];
      r_start_s <= r_start_m;
      r_start_q <= r_start_s;
      r_dvd     <= w_dvd_n;
      r_dvs     <= w_dvs_n;
      r_q       <= w_q_n;
      r_rem     <= w_rem_n;
      r_dz      <= w_dz_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_cnt     <= w_cnt_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_dvd_n   = r_dvd;
    w_dvs_n   = r_dvs;
    w_q_n     = r_q;
    w_rem_n   = r_rem;
    w_dz_n    = r_dz;
    w_busy_n  = r_busy;
    w_done_n  = r_done;
    w_cnt_n   = r_cnt;

    unique case (r_state)
      IDLE, DONE: begin
        if (w_start_edge) begin
          w_dvd_n   = bus.ui_in[DW-1:0];
          w_dvs_n   = bus.uio_in[VW-1:0];
          w_q_n     = '0;
          w_rem_n   = '0;
          w_dz_n    = 1'b0;
          w_busy_n  = 1'b1;
          w_done_n  = 1'b0;
          w_cnt_n   = CW'(DW - 1);
          w_state_n = RUN;
        end
      end
      RUN: begin
        // A zero divisor skips the datapath but still burns DW cycles so the
        // handshake timing is identical to a normal divide.
        if (r_dvs != '0) begin
          w_dvd_n = r_dvd << 1;
          if (w_rem5 >= {1'b0, r_dvs}) begin
            w_rem_n = w_diff[VW-1:0];
            w_q_n   = {r_q[DW-2:0], 1'b1};
          end else begin
            w_rem_n = w_rem5[VW-1:0];
            w_q_n   = {r_q[DW-2:0], 1'b0};
          end
        end
        if (r_cnt == '0) begin
          w_state_n = DONE;
          w_busy_n  = 1'b0;
          w_done_n  = 1'b1;
          if (r_dvs == '0) begin
            w_q_n   = '1;
            w_rem_n = '1;
            w_dz_n  = 1'b1;
          end
        end else begin
          w_cnt_n = r_cnt - 1'b1;
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign bus.uo_out  = bus.uio_in[5] ? {r_dz, {(8 - 1 - VW){1'b0}}, r_rem} : r_q;
  assign bus.uio_out = {r_done, r_busy, 6'b00_0000};
  assign bus.uio_oe  = 8'b1100_0000;
endmodule

module tt_um_secd_8_seq_div (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  tt_um_secd_8_seq_div_if w_bus ();

  assign w_bus.ena    = ena;
  assign w_bus.ui_in  = ui_in;
  assign w_bus.uio_in = uio_in;
  assign uo_out       = w_bus.uo_out;
  assign uio_out      = w_bus.uio_out;
  assign uio_oe       = w_bus.uio_oe;

  tt_um_secd_8_seq_div_core #(
    .DW (8),
    .VW (4)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (w_bus.slave)
  );
endmodule

// File: tb/tb_tt_um_secd_8_seq_div.sv
module tb_tt_um_secd_8_seq_div;
  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  tt_um_secd_8_seq_div_if pins ();

  tt_um_secd_8_seq_div dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (pins.ena),
    .ui_in   (pins.ui_in),
    .uio_in  (pins.uio_in),
    .uo_out  (pins.uo_out),
    .uio_out (pins.uio_out),
    .uio_oe  (pins.uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] dvd;
    logic [3:0] dvs;
    logic [7:0] q;
    logic [3:0] r;
    logic       dz;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  // Returns 1 once busy is seen at a falling edge, within a bounded window.
  task automatic wait_busy(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (pins.uio_out[6]) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_busy(output int cnt);
    cnt = 0;
    while (pins.uio_out[6] && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
  endtask

  task automatic check_result(input logic [7:0] eq, input logic [3:0] er,
                              input logic edz, input string tag);
    pins.uio_in[5] = 1'b0;
    #1;
    chk({tag, " quot"}, pins.uo_out, eq);
    pins.uio_in[5] = 1'b1;
    #1;
    chk({tag, " rem_view"}, pins.uo_out, {edz, 3'b000, er});
    pins.uio_in[5] = 1'b0;
  endtask

  task automatic run_and_check(input logic [7:0] a, input logic [3:0] b,
                               input logic [7:0] eq, input logic [3:0] er,
                               input logic edz, input string tag);
    bit seen;
    int cnt;
    @(negedge clk);
    pins.ui_in  = a;
    pins.uio_in = {3'b000, 1'b1, b};
    @(negedge clk);
    pins.uio_in[4] = 1'b0;
    wait_busy(seen);
    chk({tag, " busy_rise"}, {7'b0, seen}, 8'h01);
    chk({tag, " done_clr_at_capture"}, {7'b0, pins.uio_out[7]}, 8'h00);
    count_busy(cnt);
    chk({tag, " busy_cycles"}, 8'(cnt), 8'd8);
    chk({tag, " done"}, pins.uio_out, 8'h80);
    check_result(eq, er, edz, tag);
  endtask

  initial begin
    bit seen;
    int cnt;
    int rises;
    bit prev_busy;
    bit bad;

    n_tests = 0;
    n_fail  = 0;

    vecs[0]  = '{dvd: 8'd200, dvs: 4'd7,  q: 8'h1C, r: 4'd4,  dz: 1'b0};
    vecs[1]  = '{dvd: 8'd255, dvs: 4'd1,  q: 8'hFF, r: 4'd0,  dz: 1'b0};
    vecs[2]  = '{dvd: 8'd0,   dvs: 4'd5,  q: 8'h00, r: 4'd0,  dz: 1'b0};
    vecs[3]  = '{dvd: 8'd13,  dvs: 4'd0,  q: 8'hFF, r: 4'hF,  dz: 1'b1};
    vecs[4]  = '{dvd: 8'd100, dvs: 4'd3,  q: 8'h21, r: 4'd1,  dz: 1'b0};
    vecs[5]  = '{dvd: 8'd9,   dvs: 4'd2,  q: 8'h04, r: 4'd1,  dz: 1'b0};
    vecs[6]  = '{dvd: 8'd15,  dvs: 4'd15, q: 8'h01, r: 4'd0,  dz: 1'b0};
    vecs[7]  = '{dvd: 8'd14,  dvs: 4'd15, q: 8'h00, r: 4'd14, dz: 1'b0};
    vecs[8]  = '{dvd: 8'd255, dvs: 4'd15, q: 8'h11, r: 4'd0,  dz: 1'b0};
    vecs[9]  = '{dvd: 8'd128, dvs: 4'd9,  q: 8'h0E, r: 4'd2,  dz: 1'b0};
    vecs[10] = '{dvd: 8'd250, dvs: 4'd13, q: 8'h13, r: 4'd3,  dz: 1'b0};

    rst_n       = 1'b0;
    pins.ena    = 1'b1;
    pins.ui_in  = 8'h00;
    pins.uio_in = 8'h00;
    #1;
    chk("reset uo_out", pins.uo_out, 8'h00);
    chk("reset uio_out", pins.uio_out, 8'h00);
    chk("uio_oe", pins.uio_oe, 8'hC0);
    pins.uio_in[5] = 1'b1;
    #1;
    chk("reset rem_view", pins.uo_out, 8'h00);
    pins.uio_in[5] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i])
      run_and_check(vecs[i].dvd, vecs[i].dvs, vecs[i].q, vecs[i].r, vecs[i].dz,
                    $sformatf("vec%0d %0d/%0d", i, vecs[i].dvd, vecs[i].dvs));

    // start held high for 40 clocks: exactly one operation
    @(negedge clk);
    pins.ui_in  = 8'd100;
    pins.uio_in = {3'b000, 1'b1, 4'd3};
    rises     = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (pins.uio_out[6] && !prev_busy) rises++;
      prev_busy = pins.uio_out[6];
    end
    chk("held_start busy_rises", 8'(rises), 8'd1);
    chk("held_start done", pins.uio_out, 8'h80);
    check_result(8'h21, 4'd1, 1'b0, "held_start");
    pins.uio_in[4] = 1'b0;
    repeat (3) @(negedge clk);
    run_and_check(8'd9, 4'd2, 8'h04, 4'd1, 1'b0, "from_done 9/2");

    // reset asserted at E4 of 200/7
    @(negedge clk);
    pins.ui_in  = 8'd200;
    pins.uio_in = {3'b000, 1'b1, 4'd7};
    @(negedge clk);
    pins.uio_in[4] = 1'b0;
    wait_busy(seen);
    chk("rst_mid busy_rise", {7'b0, seen}, 8'h01);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid uo_out", pins.uo_out, 8'h00);
    chk("rst_mid uio_out", pins.uio_out, 8'h00);
    pins.uio_in[5] = 1'b1;
    #1;
    chk("rst_mid rem_view", pins.uo_out, 8'h00);
    pins.uio_in[5] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (pins.uio_out != 8'h00) bad = 1'b1;
    end
    chk("rst_mid no_done_pulse", {7'b0, bad}, 8'h00);

    // operands and start toggled during RUN are ignored
    @(negedge clk);
    pins.ui_in  = 8'd200;
    pins.uio_in = {3'b000, 1'b1, 4'd7};
    @(negedge clk);
    pins.uio_in[4] = 1'b0;
    wait_busy(seen);
    chk("toggle busy_rise", {7'b0, seen}, 8'h01);
    pins.ui_in  = 8'h55;
    pins.uio_in = {3'b000, 1'b1, 4'd3};
    cnt = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (pins.uio_out[6]) cnt++;
    end
    pins.uio_in[4] = 1'b0;
    pins.ui_in     = 8'hAA;
    while (pins.uio_out[6] && cnt < 20) begin
      @(negedge clk);
      if (pins.uio_out[6]) cnt++;
    end
    chk("toggle busy_cycles", 8'(cnt), 8'd8);
    chk("toggle done", pins.uio_out, 8'h80);
    check_result(8'h1C, 4'd4, 1'b0, "toggle 200/7");
    bad = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (pins.uio_out != 8'h80) bad = 1'b1;
    end
    chk("toggle no_restart", {7'b0, bad}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
